fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the branch/jump resolution logic.
- Holds the architectural PC and issues in-order requests to instruction memory over a valid/ready request channel, with a fixed-order response channel.
- Buffers returned instructions with their PCs and presents them to decode over a valid/ready interface.
- Consumes the redirect (pc_src, target_pc) produced by branch resolution. On redirect it flushes buffered instructions and silently drops responses still in flight.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/sync_fifo.sv | 62 ++++++
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, reset PC default and the decode-buffer entry type for the fetch stage.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a one-cycle flush; rdata_o always shows the head entry.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0) && !flush_i;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push_i && (!full || do_pop) && !flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited in-order fetch from imem, with a redirect
// path that flushes the decode buffer and drops responses still in flight.
module fetch_unit #(
  parameter int              XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = fetch_pkg::DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_src,
  input  logic [XLEN-1:0] target_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr
);
  import fetch_pkg::*;

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   outstanding, occupancy;
  logic [XLEN-1:0] pq_head;
  fetch_entry_t    buf_wdata, buf_head;
  logic [CW:0]     in_use;
  logic            if_pop, has_credit, req_fire, rsp_keep;

  assign if_valid = (occupancy != '0);
  assign if_pop   = if_valid && if_ready;
  assign in_use   = {1'b0, outstanding} + {1'b0, occupancy};

  // A decode pop in this cycle frees its slot for a request issued in the same cycle,
  // which is what sustains one instruction per cycle with a 1-cycle memory.
  assign has_credit     = (in_use < DEPTH_W) || (if_pop && (in_use == DEPTH_W));
  assign imem_req_valid = rst_n && has_credit && !pc_src;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (drop_q == '0) && !pc_src;

  always_comb begin
    pc_d = pc_q;
    if (pc_src)        pc_d = target_pc & ~XLEN'(3);
    else if (req_fire) pc_d = pc_q + XLEN'(4);
  end

  always_comb begin
    drop_d = drop_q;
    if (pc_src)                                drop_d = outstanding - CW'(imem_rsp_valid);
    else if (imem_rsp_valid && drop_q != '0)   drop_d = drop_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  // Every response pops the PC queue, so its count is the outstanding-request count.
  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (req_fire),
    .pop_i   (imem_rsp_valid),
    .flush_i (1'b0),
    .wdata_i (pc_q),
    .rdata_o (pq_head),
    .count_o (outstanding)
  );

  assign buf_wdata = '{pc: pq_head, instr: imem_rsp_data};

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_ibuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rsp_keep),
    .pop_i   (if_pop),
    .flush_i (pc_src),
    .wdata_i (buf_wdata),
    .rdata_o (buf_head),
    .count_o (occupancy)
  );

  assign if_pc    = if_valid ? buf_head.pc    : '0;
  assign if_instr = if_valid ? buf_head.instr : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, redirect/reset corner
// sequences, and a randomized run against a queue-based reference model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk, rst_n, pc_src, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        if_valid, if_ready;
  logic [31:0] target_pc, imem_req_addr, imem_rsp_data, if_pc, if_instr;

  fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_src         (pc_src),
    .target_pc      (target_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Memory: in-order responses; live: accepted requests of the current redirect epoch
  // that decode has not yet consumed (arr = cycle the response arrived, -1 if not yet).
  typedef struct { int due; int id; logic [31:0] data; } mem_t;
  typedef struct { int id; logic [31:0] pc; logic [31:0] instr; int arr; } live_t;
  typedef struct { bit if_rdy; bit e_rv; logic [31:0] e_addr; bit e_ifv; logic [31:0] e_pc; } vec_t;

  mem_t        memq[$];
  live_t       live[$];
  int          cyc, n_cmp, n_bad, next_id, last_due, lat_min, lat_max;
  bit          data_is_addr;
  logic [31:0] exp_pc;
  logic        obs_rv, obs_ifv;
  logic [31:0] obs_addr, obs_ifpc, obs_instr;
  vec_t        vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive memory response, compare outputs with the model, advance the model.
  task automatic cycle();
    bit          rsp_now, exp_ifv, hs, exp_rv;
    int          occ, credit, lat, due;
    mem_t        m;
    logic [31:0] d;
    rsp_now        = (memq.size() > 0) && (memq[0].due <= cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? memq[0].data : 32'h0;
    #2;
    occ = 0;
    foreach (live[i]) if (live[i].arr >= 0 && live[i].arr < cyc) occ++;
    exp_ifv = (occ > 0);
    hs      = exp_ifv && if_ready;
    credit  = DEPTH - memq.size() - occ + (hs ? 1 : 0);
    exp_rv  = !pc_src && (credit > 0);
    obs_rv = imem_req_valid; obs_addr = imem_req_addr;
    obs_ifv = if_valid; obs_ifpc = if_pc; obs_instr = if_instr;
    check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) check("req_addr", imem_req_addr, exp_pc);
    check("if_valid", 32'(if_valid), 32'(exp_ifv));
    if (exp_ifv) begin
      check("if_pc", if_pc, live[0].pc);
      check("if_instr", if_instr, live[0].instr);
    end
    if (hs) void'(live.pop_front());
    if (rsp_now) begin
      m = memq.pop_front();
      if (!pc_src) foreach (live[i]) if (live[i].id == m.id) live[i].arr = cyc;
    end
    if (pc_src) begin
      live.delete();
      exp_pc = target_pc & ~32'h3;
    end else if (exp_rv && imem_req_ready) begin
      d   = data_is_addr ? exp_pc : $urandom;
      lat = int'($urandom_range(lat_max, lat_min));
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      memq.push_back('{due, next_id, d});
      live.push_back('{next_id, exp_pc, d, -1});
      next_id++;
      last_due = due;
      exp_pc   = exp_pc + 32'd4;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // With if_ready high every valid cycle is a delivery; check the next one's PC.
  task automatic next_deliv(input string name, input logic [31:0] exp);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      cycle();
      got = obs_ifv;
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no delivery within 30 cycles, expected pc %h", name, exp);
    end else check(name, obs_ifpc, exp);
  endtask

  task automatic wait_outstanding(input string name, input int n);
    for (int k = 0; k < 20 && memq.size() != n; k++) cycle();
    if (memq.size() != n) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: %0d requests outstanding, expected %0d", name, memq.size(), n);
    end
  endtask

  function automatic bit live_rsp_due();
    if (memq.size() == 0 || memq[0].due > cyc) return 1'b0;
    foreach (live[i]) if (live[i].id == memq[0].id) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    logic [31:0] held;
    n_cmp = 0; n_bad = 0; cyc = 0; next_id = 0; last_due = -1;
    lat_min = 1; lat_max = 1; data_is_addr = 1'b1; exp_pc = RST_PC;
    rst_n = 1'b0; pc_src = 1'b0; target_pc = '0; imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; if_ready = 1'b0;

    //            if_rdy rv    addr      ifv   if_pc
    vecs[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
    vecs[2]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    vecs[3]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    vecs[4]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    vecs[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    vecs[6]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    vecs[7]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    vecs[8]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    vecs[9]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
    vecs[10] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h10};

    @(negedge clk);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_req_addr", imem_req_addr, RST_PC);
    @(negedge clk);
    rst_n = 1'b1;

    // Stall from reset, then release: 1-cycle memory returning addr as data.
    for (int i = 0; i < 11; i++) begin
      if_ready = vecs[i].if_rdy;
      cycle();
      check($sformatf("vec%0d_rv", i), 32'(obs_rv), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv) check($sformatf("vec%0d_addr", i), obs_addr, vecs[i].e_addr);
      check($sformatf("vec%0d_ifv", i), 32'(obs_ifv), 32'(vecs[i].e_ifv));
      if (vecs[i].e_ifv) begin
        check($sformatf("vec%0d_pc", i), obs_ifpc, vecs[i].e_pc);
        check($sformatf("vec%0d_instr", i), obs_instr, vecs[i].e_pc);
      end
    end

    // Redirect with two requests in flight at latency 3: both are dropped.
    lat_min = 3; lat_max = 3; data_is_addr = 1'b0;
    wait_outstanding("t3_fill", 2);
    pc_src = 1'b1; target_pc = 32'h100;
    cycle();
    pc_src = 1'b0;
    next_deliv("t3_first_pc", 32'h100);
    next_deliv("t3_second_pc", 32'h104);

    // Redirect to an unaligned target in the same cycle as a live response.
    lat_min = 1; lat_max = 1;
    for (int k = 0; k < 20 && !live_rsp_due(); k++) cycle();
    pc_src = 1'b1; target_pc = 32'h203;
    cycle();
    check("t4_rv_in_redirect", 32'(obs_rv), 32'd0);
    pc_src = 1'b0;
    cycle();
    check("t4_rv_after", 32'(obs_rv), 32'd1);
    check("t4_addr_after", obs_addr, 32'h200);
    next_deliv("t4_first_pc", 32'h200);

    // Memory not ready: request held stable, pc does not advance.
    for (int k = 0; k < 3; k++) cycle();
    imem_req_ready = 1'b0;
    held = exp_pc;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("t5_valid_held", 32'(obs_rv), 32'd1);
      check("t5_addr_held", obs_addr, held);
    end
    imem_req_ready = 1'b1;
    next_deliv("t5_resume_pc", held);

    // Asynchronous reset in mid-cycle with two requests outstanding.
    lat_min = 3; lat_max = 3;
    wait_outstanding("t6_fill", 2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_req_valid", 32'(imem_req_valid), 32'd0);
    check("t6_if_valid", 32'(if_valid), 32'd0);
    check("t6_if_pc", if_pc, 32'd0);
    check("t6_if_instr", if_instr, 32'd0);
    check("t6_req_addr", imem_req_addr, RST_PC);
    imem_rsp_valid = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    memq.delete(); live.delete();
    exp_pc = RST_PC; last_due = -1;
    rst_n = 1'b1;
    cycle();
    check("t6_restart_rv", 32'(obs_rv), 32'd1);
    check("t6_restart_addr", obs_addr, RST_PC);
    next_deliv("t6_first_pc", RST_PC);

    // Randomized traffic against the model.
    lat_min = 1; lat_max = 4;
    for (int k = 0; k < 3000; k++) begin
      if_ready       = ($urandom_range(9, 0) < 7);
      imem_req_ready = ($urandom_range(3, 0) != 0);
      pc_src         = ($urandom_range(19, 0) == 0);
      target_pc      = $urandom;
      cycle();
    end
    pc_src = 1'b0; imem_req_ready = 1'b0; if_ready = 1'b1;
    for (int k = 0; k < 40 && (live.size() != 0 || memq.size() != 0); k++) cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
